fifo_ctl_1024x8: RTL and testbench

Single-clock FIFO controller that drives the 1024x8 simple dual-port inferred RAM (registered read, one-cycle latency) and turns it into a streaming FIFO. It generates the RAM's write address, data and enable plus its read address. It captures the RAM read data into a 2-entry output buffer. Upstream and downstream agents see it through valid/ready handshakes. It sits directly upstream of the RAM's write port and directly downstream of its read port. In the top level both RAM clocks are tied to `Clk`.

---
 rtl/fifo_ctl_1024x8.sv | 101 ++++++++++
 tb/tb_fifo_ctl_1024x8.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctl_1024x8.sv
// fifo_ctl_1024x8: streaming FIFO controller around a 1024x8 registered-read RAM with a 2-entry output buffer.
// Define FIFO_CTL_1024X8_ALMOST_EN to add registered almost_full/almost_empty flags.
module fifo_ctl_1024x8 #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter int DATA_W = 8
`ifdef FIFO_CTL_1024X8_ALMOST_EN
  ,
  parameter int AF_THRESH = 1020,
  parameter int AE_THRESH = 4
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   fill_level,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic              WEN,
  output logic              WClk_En,
  output logic [ADDR_W-1:0] RA,
  output logic              RClk_En,
  input  logic [DATA_W-1:0] RD
`ifdef FIFO_CTL_1024X8_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt_q, ram_cnt_d, fill_q, fill_d;
  logic inflight_q, inflight_d;
  logic [1:0] ob_cnt_q, ob_cnt_d, base;
  logic [DATA_W-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
  logic push_fire, pop_fire, rd_issue;
  // base is the buffer occupancy after this cycle's pop, i.e. the slot a capture lands in
  always_comb begin
    push_ready = !Rst && ram_cnt_q < FULL;
    push_fire = push_valid && push_ready;
    pop_valid = ob_cnt_q != 2'd0;
    pop_fire = pop_valid && pop_ready;
    base = ob_cnt_q - 2'(pop_fire);
    rd_issue = ram_cnt_q != '0 && 3'(base) + 3'(inflight_q) < 3'd2;
    wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(push_fire);
    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_issue);
    ram_cnt_d = wr_ptr_d - rd_ptr_d;
    inflight_d = rd_issue;
    ob_cnt_d = base + 2'(inflight_q);
    ob0_d = inflight_q && base == 2'd0 ? RD : (pop_fire ? ob1_q : ob0_q);
    ob1_d = inflight_q && base == 2'd1 ? RD : ob1_q;
    fill_d = ram_cnt_d + (ADDR_W+1)'(inflight_d) + (ADDR_W+1)'(ob_cnt_d);
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ram_cnt_q <= '0;
      fill_q <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q <= '0;
      ob0_q <= '0;
      ob1_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      fill_q <= fill_d;
      inflight_q <= inflight_d;
      ob_cnt_q <= ob_cnt_d;
      ob0_q <= ob0_d;
      ob1_q <= ob1_d;
    end
  end
  assign WA = wr_ptr_q[ADDR_W-1:0];
  assign WD = push_data;
  assign WEN = push_fire;
  assign WClk_En = push_fire;
  assign RA = rd_ptr_q[ADDR_W-1:0];
  assign RClk_En = rd_issue;
  assign pop_data = ob0_q;
  assign fill_level = fill_q;
`ifdef FIFO_CTL_1024X8_ALMOST_EN
  logic af_q, ae_q;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= fill_d >= (ADDR_W+1)'(AF_THRESH);
      ae_q <= fill_d <= (ADDR_W+1)'(AE_THRESH);
    end
  end
  assign almost_full = af_q;
  assign almost_empty = ae_q;
`endif
endmodule

// File: tb/tb_fifo_ctl_1024x8.sv
// tb_fifo_ctl_1024x8: directed bench for fifo_ctl_1024x8 with a registered-read RAM model and a pop-side scoreboard.
module tb_fifo_ctl_1024x8;
  logic Clk, Rst, push_valid, push_ready, pop_valid, pop_ready, WEN, WClk_En, RClk_En;
  logic [7:0] push_data, pop_data, WD, RD;
  logic [10:0] fill_level;
  logic [9:0] WA, RA;
`ifdef FIFO_CTL_1024X8_ALMOST_EN
  logic almost_full, almost_empty;
`endif
  logic [7:0] mem [1024];
  logic [7:0] q[$];
  int errors = 0, checks = 0, pops = 0;

  fifo_ctl_1024x8 dut (
    .Clk(Clk), .Rst(Rst), .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data), .fill_level(fill_level),
    .WA(WA), .WD(WD), .WEN(WEN), .WClk_En(WClk_En), .RA(RA), .RClk_En(RClk_En), .RD(RD)
`ifdef FIFO_CTL_1024X8_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (WEN) mem[WA] <= WD;
    if (RClk_En) RD <= mem[RA];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(output logic f);
    @(negedge Clk);
    f = push_valid && push_ready;
    @(posedge Clk);
    #1;
    if (f) push_data = push_data + 8'd1;
  endtask

  task automatic drain();
    logic f;
    int g = 0;
    push_valid = 0;
    pop_ready = 1;
    while (fill_level != 0 && g < 3000) begin
      step(f);
      g++;
    end
    chk("drain_done", int'(fill_level), 0);
    chk("sb_empty", q.size(), 0);
    pop_ready = 0;
  endtask

  task automatic fill_to(input int lvl);
    logic f;
    int g = 0;
    push_valid = 1;
    pop_ready = 0;
    while (int'(fill_level) != lvl && g < 1200) begin
      step(f);
      g++;
    end
    chk("fill_reached", int'(fill_level), lvl);
  endtask

  // Scoreboard: accepted pushes queue up, fired pops are checked in order.
  initial forever begin
    @(negedge Clk);
    if (push_valid && push_ready) q.push_back(push_data);
    if (pop_valid && pop_ready) begin
      pops++;
      if (q.size() == 0) chk("pop_underflow", 1, 0);
      else chk("pop_data", int'(pop_data), int'(q.pop_front()));
    end
    if (WEN && RClk_En) chk("addr_collision", int'(WA == RA), 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic f;
    int n, extra, p0, bad, ae_at, af_at;
    Clk = 0;
    Rst = 0;
    push_valid = 1;
    pop_ready = 1;
    push_data = 8'h11;
    #1 Rst = 1;
    #1;
    chk("rst_pop_valid", int'(pop_valid), 0);
    chk("rst_pop_data", int'(pop_data), 0);
    chk("rst_fill", int'(fill_level), 0);
    chk("rst_push_ready", int'(push_ready), 0);
    chk("rst_wen", int'(WEN), 0);
    chk("rst_rclk_en", int'(RClk_En), 0);
    chk("rst_wa", int'(WA), 0);
    chk("rst_ra", int'(RA), 0);
`ifdef FIFO_CTL_1024X8_ALMOST_EN
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ae", int'(almost_empty), 1);
`endif
    repeat (2) @(posedge Clk);
    #1;
    push_valid = 0;
    pop_ready = 0;
    Rst = 0;
    // single word latency
    push_valid = 1;
    push_data = 8'hA5;
    @(negedge Clk);
    chk("t1_wen", int'(WEN), 1);
    chk("t1_wa", int'(WA), 0);
    @(posedge Clk);
    #1 push_valid = 0;
    @(negedge Clk);
    chk("t1_rclk_en", int'(RClk_En), 1);
    chk("t1_ra", int'(RA), 0);
    chk("t1_fill_k", int'(fill_level), 1);
    chk("t1_valid_k", int'(pop_valid), 0);
    @(negedge Clk);
    chk("t1_rclk_en_k1", int'(RClk_En), 0);
    chk("t1_valid_k1", int'(pop_valid), 0);
    chk("t1_fill_k1", int'(fill_level), 1);
    @(negedge Clk);
    chk("t1_valid_k2", int'(pop_valid), 1);
    chk("t1_data_k2", int'(pop_data), 8'hA5);
    chk("t1_fill_k2", int'(fill_level), 1);
    @(posedge Clk);
    #1 drain();
    // fill to capacity: 1024 in RAM plus 2 in the output buffer
    push_data = 8'h00;
    push_valid = 1;
    n = 0;
    for (int g = 0; g < 1100 && n < 1026; g++) begin
      step(f);
      if (f) n++;
    end
    chk("fill_pushes", n, 1026);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step(f);
      if (f) extra++;
    end
    chk("full_no_push", extra, 0);
    chk("full_push_ready", int'(push_ready), 0);
    chk("full_fill", int'(fill_level), 1026);
    // 1 + 1026 words written since reset: write pointer wrapped to address 3
    chk("full_wa_wrap", int'(WA), 3);
    p0 = pops;
    drain();
    chk("drain_count", pops - p0, 1026);
    // full with both sides streaming
    fill_to(1026);
    pop_ready = 1;
    n = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(f);
      if (f) n++;
      if (fill_level < 11'd1024 || fill_level > 11'd1026) bad++;
    end
    chk("full_stream_pushes", n, 39);
    chk("full_stream_range", bad, 0);
    drain();
    // random handshakes
    for (int i = 0; i < 3000; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      pop_ready = 1'($urandom_range(0, 1));
      step(f);
    end
    drain();
    // reset mid-stream
    push_data = 8'h80;
    fill_to(500);
    Rst = 1;
    #1;
    chk("mid_rst_pop_valid", int'(pop_valid), 0);
    chk("mid_rst_pop_data", int'(pop_data), 0);
    chk("mid_rst_fill", int'(fill_level), 0);
    chk("mid_rst_push_ready", int'(push_ready), 0);
    chk("mid_rst_wen", int'(WEN), 0);
    chk("mid_rst_rclk_en", int'(RClk_En), 0);
    chk("mid_rst_wa", int'(WA), 0);
    chk("mid_rst_ra", int'(RA), 0);
    q.delete();
    @(posedge Clk);
    #1 Rst = 0;
    push_data = 8'h3C;
    push_valid = 1;
    step(f);
    push_valid = 0;
    for (int g = 0; g < 10 && !pop_valid; g++) step(f);
    chk("post_rst_valid", int'(pop_valid), 1);
    chk("post_rst_head", int'(pop_data), 8'h3C);
    drain();
`ifdef FIFO_CTL_1024X8_ALMOST_EN
    ae_at = -1;
    af_at = -1;
    push_valid = 1;
    for (int g = 0; g < 1100 && fill_level < 11'd1022; g++) begin
      step(f);
      if (ae_at < 0 && !almost_empty) ae_at = int'(fill_level);
      if (af_at < 0 && almost_full) af_at = int'(fill_level);
    end
    chk("ae_fall_at", ae_at, 5);
    chk("af_rise_at", af_at, 1020);
    drain();
    chk("ae_after_drain", int'(almost_empty), 1);
`else
    ae_at = 0;
    af_at = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
